// File: rtl/fp_decode_sp_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_decode_sp_pipeline_pkg
// Description : Shared widths, recoded-format constants and exponent-class
//               helper for the single-precision recoded -> binary32 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_decode_sp_pipeline_pkg;

    localparam int FPR_WIDTH         = 64;
    localparam int FPR_RECODED_WIDTH = 65;
    localparam int SP_RECODED_WIDTH  = 33;
    localparam int SP_WIDTH          = 32;
    localparam int FPU_EXC_WIDTH     = 5;

    // Default pipeline depth of the decode path
    localparam int FPU_PIPE_DECODE_S = 2;

    // Top three bits of the 9-bit recoded exponent that mark special values
    localparam logic [2:0] SP_RECODED_EXP_ZERO = 3'b000;
    localparam logic [2:0] SP_RECODED_EXP_INF  = 3'b110;
    localparam logic [2:0] SP_RECODED_EXP_NAN  = 3'b111;

    // Recoded exponent landmarks
    localparam logic [8:0] SP_RECODED_BIAS_ADJ  = 9'h81;   // also the largest subnormal exponent
    localparam logic [8:0] SP_RECODED_NORM_MIN  = 9'h82;
    localparam logic [8:0] SP_RECODED_NORM_MAX  = 9'h17F;
    localparam logic [8:0] SP_RECODED_SUB_MIN   = 9'h6B;

    localparam logic [31:0] SP_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [22:0] SP_QNAN_FRAC  = 23'h40_0000;
    localparam logic [31:0] SP_NANBOX_HI  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SP_CLS_ZERO    = 3'd0,
        SP_CLS_INF     = 3'd1,
        SP_CLS_NAN     = 3'd2,
        SP_CLS_NORM    = 3'd3,
        SP_CLS_SUB     = 3'd4,
        SP_CLS_INVALID = 3'd5
    } sp_class_e;

    // Classify a recoded exponent; codes the recoder never emits map to INVALID
    function automatic sp_class_e sp_classify(input logic [8:0] e);
        if (e[8:6] == SP_RECODED_EXP_ZERO)
            return SP_CLS_ZERO;
        else if (e[8:6] == SP_RECODED_EXP_INF)
            return SP_CLS_INF;
        else if (e[8:6] == SP_RECODED_EXP_NAN)
            return SP_CLS_NAN;
        else if ((e >= SP_RECODED_NORM_MIN) && (e <= SP_RECODED_NORM_MAX))
            return SP_CLS_NORM;
        else if ((e >= SP_RECODED_SUB_MIN) && (e <= SP_RECODED_BIAS_ADJ))
            return SP_CLS_SUB;
        else
            return SP_CLS_INVALID;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_decode_sp_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_decode_sp_pipeline_if
// Description : Operand-in / result-out valid-ready bundle of the decoder.
//               slave = decoder view, master = producer/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_decode_sp_pipeline_if;
    import fp_decode_sp_pipeline_pkg::*;

    logic                          in_val;
    logic                          in_rdy;
    logic [FPR_RECODED_WIDTH-1:0]  in_data;
    logic                          out_val;
    logic                          out_rdy;
    logic [FPR_WIDTH-1:0]          result;
    logic [FPU_EXC_WIDTH-1:0]      exc;

    modport slave (
        input  in_val, in_data, out_rdy,
        output in_rdy, out_val, result, exc
    );

    modport master (
        output in_val, in_data, out_rdy,
        input  in_rdy, out_val, result, exc
    );
endinterface
`default_nettype wire

// File: rtl/fp_decode_sp_pipeline_conv.sv
`default_nettype none
// ============================================================================
// Module      : recodedFloatNToFloatN_sp
// Description : Combinational 33-bit recoded single -> IEEE-754 binary32.
//               Build option FPU_DECODE_CANON_NAN_EN: every NaN becomes the
//               canonical quiet NaN; otherwise sign and payload are kept.
// Revision    : 1.0 - initial release
// ============================================================================
module recodedFloatNToFloatN_sp
    import fp_decode_sp_pipeline_pkg::*;
(
    input  wire logic [SP_RECODED_WIDTH-1:0] rec_i,
    output logic      [SP_WIDTH-1:0]         fp_o
);

    logic        w_sign;
    logic [8:0]  w_exp;
    logic [22:0] w_frac;
    sp_class_e   w_cls;
    logic [7:0]  w_norm_exp;
    logic [4:0]  w_sub_sh;
    logic [22:0] w_sub_mant;

    assign w_sign = rec_i[32];
    assign w_exp  = rec_i[31:23];
    assign w_frac = rec_i[22:0];
    assign w_cls  = sp_classify(w_exp);

    // Normal: remove the recoding bias; the range check guarantees 1..254
    assign w_norm_exp = 8'(w_exp - SP_RECODED_BIAS_ADJ);
    // Subnormal: restore the hidden one and shift it back down (1..23 places)
    assign w_sub_sh   = 5'(SP_RECODED_NORM_MIN - w_exp);
    assign w_sub_mant = 23'({1'b1, w_frac} >> w_sub_sh);

    // Select the binary32 encoding for the decoded class
    always_comb begin
        fp_o = {w_sign, 31'b0};
        case (w_cls)
            SP_CLS_ZERO: fp_o = {w_sign, 31'b0};
            SP_CLS_INF:  fp_o = {w_sign, 8'hFF, 23'b0};
            SP_CLS_NAN: begin
`ifdef FPU_DECODE_CANON_NAN_EN
                fp_o = SP_CANON_NAN;
`else
                // An empty payload would read back as infinity, so make it quiet
                fp_o = {w_sign, 8'hFF, (w_frac == 23'b0) ? SP_QNAN_FRAC : w_frac};
`endif
            end
            SP_CLS_NORM: fp_o = {w_sign, w_norm_exp, w_frac};
            SP_CLS_SUB:  fp_o = {w_sign, 8'h00, w_sub_mant};
            default:     fp_o = {w_sign, 31'b0};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp_decode_sp_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : fp_decode_sp_pipeline
// Description : Elastic STAGES-deep pipeline that decodes recoded single
//               operands to NaN-boxed binary32. Decode sits ahead of stage 1;
//               the last stage drives the consumer directly.
//               Build option FPU_DECODE_CANON_NAN_EN selects NaN canonicalisation.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_decode_sp_pipeline
    import fp_decode_sp_pipeline_pkg::*;
#(
    parameter int STAGES = FPU_PIPE_DECODE_S
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    fp_decode_sp_pipeline_if.slave  io
);

    logic [STAGES-1:0]    v_q;
    logic [STAGES-1:0]    v_d;
    logic [FPR_WIDTH-1:0] data_q [STAGES];
    logic [FPR_WIDTH-1:0] data_d [STAGES];
    logic [STAGES-1:0]    w_rdy;
    logic [SP_WIDTH-1:0]  w_fp;
    logic                 w_unused_hi;

    // Only the low single-precision slice of the FPR operand carries data
    assign w_unused_hi = ^io.in_data[FPR_RECODED_WIDTH-1:SP_RECODED_WIDTH];

    recodedFloatNToFloatN_sp u_conv (
        .rec_i (io.in_data[SP_RECODED_WIDTH-1:0]),
        .fp_o  (w_fp)
    );

    // Stage k can load when any stage from k to the output is empty or the
    // consumer is taking data; flattened so there is no combinational chain
    // through a single vector
    always_comb begin
        logic w_full;
        w_rdy  = '0;
        w_full = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            w_full = 1'b1;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k) w_full = w_full & v_q[j];
            end
            w_rdy[k] = io.out_rdy | ~w_full;
        end
    end

    // Next-state of the valid bits and data: each ready stage takes its upstream
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];
        if (w_rdy[0]) begin
            v_d[0] = io.in_val;
            if (io.in_val) data_d[0] = {SP_NANBOX_HI, w_fp};
        end
        for (int k = 1; k < STAGES; k++) begin
            if (w_rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) data_d[k] = data_q[k-1];
            end
        end
    end

    // Stage registers; reset drops every in-flight operand and clears data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
        end
    end

    assign io.in_rdy  = w_rdy[0];
    assign io.out_val = v_q[STAGES-1];
    assign io.result  = data_q[STAGES-1];
    assign io.exc     = '0;

endmodule
`default_nettype wire

// File: tb/tb_fp_decode_sp_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_decode_sp_pipeline
// Description : Scoreboard bench for fp_decode_sp_pipeline (STAGES=2).
//               Honours FPU_DECODE_CANON_NAN_EN for NaN expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_decode_sp_pipeline;
    import fp_decode_sp_pipeline_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fp_decode_sp_pipeline_if ifc ();

    fp_decode_sp_pipeline #(.STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    bit          rand_rdy   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_res   = '0;
    bit          b2b_armed  = 1'b0;
    int          b2b_last   = -1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endfunction

    function automatic logic [32:0] enc(input logic s, input logic [8:0] e, input logic [22:0] f);
        return {s, e, f};
    endfunction

    // Reference recoder: binary32 -> 33-bit recoded
    function automatic logic [32:0] recode(input logic [31:0] b);
        logic        s;
        logic [7:0]  x;
        logic [22:0] m;
        int          p;
        s = b[31]; x = b[30:23]; m = b[22:0];
        if (x == 8'h00) begin
            if (m == 23'h0) return {s, 32'h0};
            p = 0;
            for (int i = 0; i < 23; i++) if (m[i]) p = i;
            return {s, 9'(9'h6B + p), 23'(m << (23 - p))};
        end else if (x == 8'hFF) begin
            return (m == 23'h0) ? {s, 9'h180, 23'h0} : {s, 9'h1C0, m};
        end
        return {s, 9'(x + 9'h81), m};
    endfunction

    function automatic logic [31:0] nan_exp(input logic [31:0] b);
`ifdef FPU_DECODE_CANON_NAN_EN
        if (b[30:23] == 8'hFF && b[22:0] != 23'h0) return 32'h7FC0_0000;
`endif
        return b;
    endfunction

    // Hold inputs for one operand until accepted; expectation queued on accept
    task automatic send(input logic [32:0] op, input logic [31:0] exp32);
        int waitc;
        waitc = 0;
        ifc.in_val  = 1'b1;
        ifc.in_data = {32'hDEAD_BEEF, op};
        forever begin
            @(negedge clk);
            if (ifc.in_rdy) begin
                exp_q.push_back({32'hFFFF_FFFF, exp32});
                @(posedge clk); #1;
                break;
            end
            waitc++;
            if (waitc > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: got in_rdy=0 for %0d cycles, required acceptance", waitc);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(posedge clk); c++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            ifc.out_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every delivered result against the scoreboard queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && ifc.out_val) check("stall_hold", ifc.result, prev_res);
            if (ifc.out_val && ifc.out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out: got result %h, required no output", ifc.result);
                end else begin
                    check("result", ifc.result, exp_q.pop_front());
                    check("exc", 64'(ifc.exc), 64'h0);
                    if (b2b_armed) begin
                        if (b2b_last >= 0) check("b2b_gap", 64'(cyc - b2b_last), 64'd1);
                        b2b_last = cyc;
                    end
                end
            end
            prev_stall = ifc.out_val && !ifc.out_rdy;
            prev_res   = ifc.result;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        ifc.in_val  = 1'b0;
        ifc.in_data = '0;
        ifc.out_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_val", 64'(ifc.out_val), 64'd0);
        check("rst_result", ifc.result, 64'h0);
        check("rst_exc", 64'(ifc.exc), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_rdy", 64'(ifc.in_rdy), 64'd1);
        ifc.out_rdy = 1'b1;

        // Recoded 1.0 and its two-cycle latency
        send(33'h080000000, 32'h3F80_0000);
        ifc.in_val = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_val", 64'(ifc.out_val), 64'd0);
        @(negedge clk);
        check("lat_cycle2_out_val", 64'(ifc.out_val), 64'd1);
        drain(10);

        // Back-to-back stream, must emerge on consecutive cycles
        b2b_armed = 1'b1; b2b_last = -1;
        send(33'h100000000, 32'h8000_0000);                 // -0
        send(33'h0C0000000, 32'h7F80_0000);                 // +inf
        send(33'h035800000, 32'h0000_0001);                 // min subnormal
        send(enc(1'b0, 9'h081, 23'h7FFFFF), 32'h007F_FFFF); // largest subnormal
        send(enc(1'b1, 9'h101, 23'h200000), 32'hC020_0000); // -2.5
        send(enc(1'b0, 9'h17F, 23'h7FFFFF), 32'h7F7F_FFFF); // max normal
        send(enc(1'b1, 9'h050, 23'h001234), 32'h8000_0000); // unused exponent code
        ifc.in_val = 1'b0;
        drain(20);
        b2b_armed = 1'b0;

        // NaN handling
`ifdef FPU_DECODE_CANON_NAN_EN
        send(33'h0E0000001, 32'h7FC0_0000);
        send(enc(1'b1, 9'h1FF, 23'h2AAAAA), 32'h7FC0_0000);
`else
        send(33'h0E0000001, 32'h7F80_0001);
        send(enc(1'b1, 9'h1FF, 23'h2AAAAA), 32'hFFAA_AAAA);
`endif
        send(33'h0E0000000, 32'h7FC0_0000);
        ifc.in_val = 1'b0;
        drain(20);

        // Backpressure: two buffered, then in_rdy drops; release and drain in order
        ifc.out_rdy = 1'b0;
        send(enc(1'b0, 9'h100, 23'h000000), 32'h3F80_0000);
        send(enc(1'b0, 9'h101, 23'h000000), 32'h4000_0000);
        ifc.in_val = 1'b0;
        @(negedge clk);
        check("bp_in_rdy", 64'(ifc.in_rdy), 64'd0);
        check("bp_out_val", 64'(ifc.out_val), 64'd1);
        @(posedge clk); #1;
        fork
            begin
                send(enc(1'b0, 9'h102, 23'h000000), 32'h4080_0000);
                send(enc(1'b1, 9'h103, 23'h400000), 32'hC140_0000);
                ifc.in_val = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                ifc.out_rdy = 1'b1;
            end
        join
        drain(20);

        // Asynchronous reset with two operands in flight
        ifc.out_rdy = 1'b0;
        send(enc(1'b0, 9'h110, 23'h000001), 32'h4780_0001);
        send(enc(1'b0, 9'h111, 23'h000002), 32'h4800_0002);
        ifc.in_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_val", 64'(ifc.out_val), 64'd0);
        check("arst_result", ifc.result, 64'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_in_rdy", 64'(ifc.in_rdy), 64'd1);
        ifc.out_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(enc(1'b1, 9'h100, 23'h000000), 32'hBF80_0000);
        ifc.in_val = 1'b0;
        drain(10);

        // Random round-trip through the reference recoder with random out_rdy
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b[30:23] = 8'h00;
                1: b[30:23] = 8'hFF;
                2: begin b[30:23] = 8'h00; b[22:0] = 23'($urandom_range(0, 3)); end
                3: b[22:0] = 23'h0;
                default: ;
            endcase
            send(recode(b), nan_exp(b));
        end
        ifc.in_val = 1'b0;
        rand_rdy   = 1'b0;
        @(posedge clk); #1;
        ifc.out_rdy = 1'b1;
        drain(50);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_decode_sp_pipeline.md
Name: fp_decode_sp_pipeline

Overview:
- Converts single-precision operands from the FPU's internal 33-bit recoded format back to IEEE-754 binary32 for FPR store and move-to-integer paths.
- Output is NaN-boxed to FPR_WIDTH by setting the upper 32 bits to ones.
- Elastic pipeline with valid/ready handshake at both ends, so it can sit between the FP register file read port and the store/writeback arbiter.

Parameters:
STAGES, 2, number of register stages (>=1); no-stall latency in cycles from input handshake to out_val.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_val  input  1  input operand valid
in_rdy  output  1  block can accept an operand this cycle
in  input  FPR_RECODED_WIDTH  recoded operand; only bits [SP_RECODED_WIDTH-1:0] used
out_val  output  1  result valid
out_rdy  input  1  consumer accepts result this cycle
result  output  FPR_WIDTH  {32'hFFFFFFFF, binary32}
exc  output  FPU_EXC_WIDTH  exception flags; always zero

Behaviour:
- Reset (reset low, async assert): all stage valid bits 0; out_val=0; data registers cleared, so result=0. in_rdy=1 one cycle after deassertion. A reset asserted mid-operation discards all in-flight operands.
- Recoded fields: s=in[32], e=in[31:23] (9b), f=in[22:0]. Decode is combinational, ahead of stage-1 register:
  - e[8:6]=000: zero; out={s,31'b0}.
  - e[8:6]=110: infinity; out={s,8'hFF,23'b0}.
  - e[8:6]=111: NaN; see Optional Feature.
  - e>=0x82 and e<=0x17F: normal; out={s,(e-9'h81)[7:0],f}.
  - 0x6B<=e<=0x81: subnormal; sh=0x82-e (1..23); out={s,8'h00,({1'b1,f}>>sh)[22:0]}. Truncation only; exact by construction.
  - Any other e (e.g. e[8:6]=001 with e<0x6B): not produced by the recoder; output {s,31'b0}. No flag.
- Handshake:
  - Transfer occurs when val&&rdy on a cycle edge.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_rdy.
  - in_rdy = !v[1] || advance[1], combinational from out_rdy through the chain. There is no path from in_val to in_rdy.
  - Full throughput: 1 operand per cycle while out_rdy=1.
  - With out_rdy held low, exactly STAGES operands are buffered, then in_rdy=0.
  - In-order delivery: no drop, no duplicate.
- Simultaneous input accept and output drain on a full pipe is legal; occupancy is unchanged.
- out_val and result come directly from last-stage registers. Result is held stable while out_val&&!out_rdy.
- exc is tied to {FPU_EXC_WIDTH{1'b0}}. Conversion raises no flags.

Optional Feature:
FPU_DECODE_CANON_NAN_EN
- Defined: every NaN decodes to the canonical 32'h7FC00000; sign and payload are discarded.
- Undefined: payload preserved; out={s,8'hFF,f}. A zero-f NaN is forced to f=23'h400000 so it never aliases infinity.

Decomposition:
- Add to fpu_common.v: SP_RECODED_EXP_ZERO (3'b000), SP_RECODED_EXP_INF (3'b110), SP_RECODED_EXP_NAN (3'b111), SP_RECODED_BIAS_ADJ (9'h81), SP_CANON_NAN (32'h7FC00000), and an FPU_PIPE_DECODE_S depth entry for STAGES.
- One combinational sub-module, recodedFloatNToFloatN_sp (33b in, 32b out). The wrapper holds only handshake and stage registers.

Test Plan:
- Recoded 1.0, in[32:0]=33'h080000000, out_rdy=1 -> out_val after 2 cycles, result=64'hFFFFFFFF3F800000, exc=0.
- Back-to-back stream:
  - -0: 33'h100000000 -> 0x80000000.
  - +inf: 33'h0C0000000 -> 0x7F800000.
  - Min subnormal: 33'h035800000 -> 0x00000001.
  - Largest subnormal: e=0x82-1=0x81, f=7FFFFF -> 0x007FFFFF.
  - All emerge on consecutive cycles in order.
- NaN 33'h0E0000001 -> 0x7FC00000 with FPU_DECODE_CANON_NAN_EN; 0x7F800001 without. 33'h0E0000000 without the macro -> 0x7FC00000.
- Backpressure: out_rdy=0, offer 4 operands -> 2 accepted, in_rdy=0. Raise out_rdy -> the 4 results arrive in order and result is stable while stalled.
- Reset pulsed low with 2 operands in flight -> out_val=0 immediately (async). After release in_rdy=1 and no stale result ever appears.
- Random recoder round-trip: 10k random binary32 -> floatNToRecodedFloatN -> this block with random out_rdy -> bit-exact match, NaNs compared per macro setting.
